// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle between the key front-end and the BCD countdown timer.
// The master drives load/start/pause/clear; the slave (timer) drives the display and status.
interface bcd_countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 2
);
  localparam int unsigned ND = MIN_DIGITS + 2;

  logic            load;
  logic [4*ND-1:0] load_value;
  logic            start;
  logic            pause;
  logic            clear;
  logic [4*ND-1:0] digits;
  logic            running;
  logic            alarm;
  logic            done;

  modport master (
    output load, load_value, start, pause, clear,
    input  digits, running, alarm, done
  );

  modport slave (
    input  load, load_value, start, pause, clear,
    output digits, running, alarm, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD MM..M:SS countdown timer with one-second prescaler and expiry alarm.
// Define BCD_TIMER_ALARM_BLINK_EN to make the alarm toggle every tick while expired.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned MIN_DIGITS = 2
) (
  input logic                  clkIn,
  input logic                  reset_btn,
  bcd_countdown_timer_if.slave tmr
);
  localparam int unsigned ND = MIN_DIGITS + 2;
  localparam int unsigned DW = 4 * ND;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            alarm_q, alarm_d;
  logic            done_q, done_d;
  logic            presc_en;
  logic            tick;
  logic [DW-1:0]   dec_val;

  // sec_10 clamps at 5, every other digit at 9.
  function automatic logic [DW-1:0] sanitise(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < ND; i++) begin
      if (i == 1) begin
        if (v[4*i +: 4] > 4'd5) r[4*i +: 4] = 4'd5;
      end else if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef BCD_TIMER_ALARM_BLINK_EN
  assign presc_en = (state_q == StRun) || (state_q == StExpired);
`else
  assign presc_en = (state_q == StRun);
`endif

  assign tick    = presc_en && (presc_q == PMax);
  assign dec_val = bcd_dec(digits_q);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (tmr.clear) begin
      state_d  = StIdle;
      digits_d = '0;
      presc_d  = '0;
    end else if (tmr.load && (state_q != StRun)) begin
      state_d  = StIdle;
      digits_d = sanitise(tmr.load_value);
    end else if (tmr.start && ((state_q == StIdle) || (state_q == StPaused)) &&
                 (|digits_q)) begin
      // Resuming from PAUSED keeps the partially elapsed second.
      state_d = StRun;
      if (state_q == StIdle) presc_d = '0;
    end else if (tmr.pause && (state_q == StRun)) begin
      state_d = StPaused;
    end else if (state_q == StRun) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        digits_d = dec_val;
        if (dec_val == '0) begin
          state_d = StExpired;
          done_d  = 1'b1;
        end
      end
`ifdef BCD_TIMER_ALARM_BLINK_EN
    end else if (state_q == StExpired) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
`endif
    end
  end

  always_comb begin
    running_d = (state_d == StRun);
`ifdef BCD_TIMER_ALARM_BLINK_EN
    if (state_d != StExpired) begin
      alarm_d = 1'b0;
    end else if (state_q != StExpired) begin
      alarm_d = 1'b1;
    end else begin
      alarm_d = tick ? ~alarm_q : alarm_q;
    end
`else
    alarm_d = (state_d == StExpired);
`endif
  end

  always_ff @(posedge clkIn) begin
    if (reset_btn) begin
      state_q   <= StIdle;
      digits_q  <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      done_q    <= done_d;
    end
  end

  assign tmr.digits  = digits_q;
  assign tmr.running = running_q;
  assign tmr.alarm   = alarm_q;
  assign tmr.done    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer at TICK_DIV=4, MIN_DIGITS=2.
// Vector table for single-cycle control behaviour, hand sequences for counting and expiry.
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_countdown_timer_if #(.MIN_DIGITS(2)) bus ();

  bcd_countdown_timer #(
    .TICK_DIV  (4),
    .MIN_DIGITS(2)
  ) dut (
    .clkIn    (clk),
    .reset_btn(rst),
    .tmr      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic        running;
    logic        alarm;
    logic        done;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        ld;
    logic [15:0] val;
    logic        st;
    logic        pa;
    logic        cl;
    logic [15:0] digits;
    logic        running;
    logic        alarm;
    logic        done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic drive(input logic r, input logic ld, input logic [15:0] val,
                       input logic st, input logic pa, input logic cl);
    rst            = r;
    bus.load       = ld;
    bus.load_value = val;
    bus.start      = st;
    bus.pause      = pa;
    bus.clear      = cl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected result is queued when stimulus is applied, then compared at the next negedge.
  task automatic cyc_check(input string name, input logic [15:0] d, input logic r,
                           input logic a, input logic dn);
    exp_t e;
    sb.push_back('{name: name, digits: d, running: r, alarm: a, done: dn});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (bus.digits === e.digits && bus.running === e.running &&
        bus.alarm === e.alarm && bus.done === e.done) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got digits=%h running=%b alarm=%b done=%b, want digits=%h running=%b alarm=%b done=%b",
               e.name, bus.digits, bus.running, bus.alarm, bus.done,
               e.digits, e.running, e.alarm, e.done);
    end
  endtask

  logic [15:0] ticks_a[6];
  logic [15:0] prev;
  logic        exp_alarm;

  initial begin
    vecs[0]  = '{"reset",          1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0};
    vecs[1]  = '{"load_0105",      0, 1, 16'h0105, 0, 0, 0, 16'h0105, 0, 0, 0};
    vecs[2]  = '{"load_clamp_00FA",0, 1, 16'h00FA, 0, 0, 0, 16'h0059, 0, 0, 0};
    vecs[3]  = '{"load_clamp_7C20",0, 1, 16'h7C20, 0, 0, 0, 16'h7920, 0, 0, 0};
    vecs[4]  = '{"load_clamp_FFFF",0, 1, 16'hFFFF, 0, 0, 0, 16'h9959, 0, 0, 0};
    vecs[5]  = '{"clear_over_load",0, 1, 16'h1234, 0, 0, 1, 16'h0000, 0, 0, 0};
    vecs[6]  = '{"start_zero",     0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0};
    vecs[7]  = '{"load_0002",      0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0};
    vecs[8]  = '{"pause_in_idle",  0, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0, 0};
    vecs[9]  = '{"start_nonzero",  0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0};
    vecs[10] = '{"clear_in_run",   0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0};
    vecs[11] = '{"load_over_start",0, 1, 16'h1000, 1, 0, 0, 16'h1000, 0, 0, 0};

    ticks_a[0] = 16'h0104;
    ticks_a[1] = 16'h0103;
    ticks_a[2] = 16'h0102;
    ticks_a[3] = 16'h0101;
    ticks_a[4] = 16'h0100;
    ticks_a[5] = 16'h0059;

    idle();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].pa, vecs[i].cl);
      cyc_check(vecs[i].name, vecs[i].digits, vecs[i].running, vecs[i].alarm, vecs[i].done);
    end
    idle();

    // Count down 01:05 across a minute boundary.
    drive(0, 1, 16'h0105, 0, 0, 0);
    cyc_check("a_load", 16'h0105, 0, 0, 0);
    drive(0, 0, 16'h0000, 1, 0, 0);
    cyc_check("a_start", 16'h0105, 1, 0, 0);
    idle();
    prev = 16'h0105;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) cyc_check("a_hold", prev, 1, 0, 0);
      cyc_check("a_tick", ticks_a[k], 1, 0, 0);
      prev = ticks_a[k];
    end
    drive(0, 0, 16'h0000, 0, 0, 1);
    cyc_check("a_clear", 16'h0000, 0, 0, 0);

    // Expiry from 00:02.
    drive(0, 1, 16'h0002, 0, 0, 0);
    cyc_check("b_load", 16'h0002, 0, 0, 0);
    drive(0, 0, 16'h0000, 1, 0, 0);
    cyc_check("b_start", 16'h0002, 1, 0, 0);
    idle();
    for (int j = 0; j < 3; j++) cyc_check("b_hold2", 16'h0002, 1, 0, 0);
    cyc_check("b_tick1", 16'h0001, 1, 0, 0);
    for (int j = 0; j < 3; j++) cyc_check("b_hold1", 16'h0001, 1, 0, 0);
    cyc_check("b_expire", 16'h0000, 0, 1, 1);
    for (int c = 1; c <= 12; c++) begin
`ifdef BCD_TIMER_ALARM_BLINK_EN
      exp_alarm = ((c / 4) % 2) == 0;
`else
      exp_alarm = 1'b1;
`endif
      if (c == 2) drive(0, 0, 16'h0000, 1, 0, 0);
      else idle();
      cyc_check("b_expired_hold", 16'h0000, 0, exp_alarm, 0);
    end
    drive(0, 1, 16'h0030, 0, 0, 0);
    cyc_check("b_load_exit", 16'h0030, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 0, 1);
    cyc_check("b_clear", 16'h0000, 0, 0, 0);

    // Pause two cycles into a second, resume, load ignored in RUN.
    drive(0, 1, 16'h1000, 0, 0, 0);
    cyc_check("c_load", 16'h1000, 0, 0, 0);
    drive(0, 0, 16'h0000, 1, 0, 0);
    cyc_check("c_start", 16'h1000, 1, 0, 0);
    drive(0, 1, 16'h0500, 0, 0, 0);
    cyc_check("c_load_in_run", 16'h1000, 1, 0, 0);
    idle();
    cyc_check("c_run", 16'h1000, 1, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0);
    cyc_check("c_pause", 16'h1000, 0, 0, 0);
    idle();
    for (int j = 0; j < 20; j++) cyc_check("c_paused", 16'h1000, 0, 0, 0);
    drive(0, 0, 16'h0000, 1, 0, 0);
    cyc_check("c_resume", 16'h1000, 1, 0, 0);
    idle();
    cyc_check("c_resume_hold", 16'h1000, 1, 0, 0);
    cyc_check("c_resume_tick", 16'h0959, 1, 0, 0);

    // Reset mid-RUN.
    cyc_check("d_run", 16'h0959, 1, 0, 0);
    drive(1, 0, 16'h0000, 0, 0, 0);
    cyc_check("d_reset", 16'h0000, 0, 0, 0);
    idle();
    for (int j = 0; j < 5; j++) cyc_check("d_after_reset", 16'h0000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
